// File: rtl/sim_run_controller.sv
// Run sequencer for a clock/reset/success DUT: holds reset, releases it, watches
// success against a cycle budget, gates tracing and latches a sticky verdict.
module sim_run_controller #(
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 21,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_success,
  output logic             dut_reset,
  output logic             trace_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    RUN  = 3'd2,
    PASS = 3'd3,
    FAIL = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_ABORT   = 2'b10;

  state_t           state;
  logic [CNT_W-1:0] rst_cnt;
  logic [CNT_W-1:0] count_inc;

  // Count value for the RUN cycle being decided; also the frozen verdict count.
  assign count_inc = cycle_count + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      dut_reset   <= 1'b1;
      trace_en    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= CODE_NONE;
    end else begin
      case (state)
        IDLE, PASS, FAIL: begin
          // Verdict and count hold here until a new run is requested.
          if (start) begin
            state       <= RST;
            rst_cnt     <= '0;
            cycle_count <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= CODE_NONE;
            dut_reset   <= 1'b1;
            trace_en    <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end

        RST: begin
          rst_cnt <= rst_cnt + CNT_W'(1);
          if (abort) begin
            state     <= FAIL;
            fail      <= 1'b1;
            fail_code <= CODE_ABORT;
            busy      <= 1'b0;
            done      <= 1'b1;
            dut_reset <= 1'b1;
            trace_en  <= 1'b0;
          end else if (rst_cnt == RST_LAST) begin
            state     <= RUN;
            dut_reset <= 1'b0;
            trace_en  <= 1'b1;
          end
        end

        RUN: begin
          cycle_count <= count_inc;
          if (abort) begin
            state     <= FAIL;
            fail      <= 1'b1;
            fail_code <= CODE_ABORT;
            busy      <= 1'b0;
            done      <= 1'b1;
            dut_reset <= 1'b1;
            trace_en  <= 1'b0;
          end else if (dut_success) begin
            state     <= PASS;
            pass      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            dut_reset <= 1'b1;
            trace_en  <= 1'b0;
          end else if (count_inc == RUN_LIMIT) begin
            state     <= FAIL;
            fail      <= 1'b1;
            fail_code <= CODE_TIMEOUT;
            busy      <= 1'b0;
            done      <= 1'b1;
            dut_reset <= 1'b1;
            trace_en  <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          dut_reset <= 1'b1;
          trace_en  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_controller.sv
// Bench for sim_run_controller: directed vector table, hand-built corner sequences,
// and randomized runs scored against an outcome model derived from the run rules.
module tb_sim_run_controller;

  localparam int RC    = 2;
  localparam int TO    = 21;
  localparam int CNT_W = 16;

  logic             clock;
  logic             reset;
  logic             start;
  logic             abort;
  logic             dut_success;
  logic             dut_reset;
  logic             trace_en;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [CNT_W-1:0] cycle_count;

  int total = 0;
  int bad   = 0;

  sim_run_controller #(
    .RESET_CYCLES  (RC),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .dut_success(dut_success),
    .dut_reset  (dut_reset),
    .trace_en   (trace_en),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code),
    .cycle_count(cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Outcome of one run from its events: the earliest of abort, first success and
  // the last budgeted cycle ends the run; ties resolve abort > success > timeout.
  task automatic model(input int ab_rst, input int ab_run, input int succ,
                       output int e_pass, output int e_fail, output int e_code, output int e_count);
    int end_k;
    if (ab_rst >= 0 && ab_rst < RC) begin
      e_pass = 0; e_fail = 1; e_code = 2; e_count = 0;
    end else begin
      end_k = TO - 1;
      if (succ >= 0 && succ < end_k) end_k = succ;
      if (ab_run >= 0 && ab_run < end_k) end_k = ab_run;
      e_count = end_k + 1;
      if (ab_run == end_k) begin
        e_pass = 0; e_fail = 1; e_code = 2;
      end else if (succ == end_k) begin
        e_pass = 1; e_fail = 0; e_code = 0;
      end else begin
        e_pass = 0; e_fail = 1; e_code = 1;
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    check($sformatf("%s.dut_reset", tag), int'(dut_reset), 1);
    check($sformatf("%s.trace_en", tag), int'(trace_en), 0);
    check($sformatf("%s.busy", tag), int'(busy), 0);
    check($sformatf("%s.done", tag), int'(done), 0);
    check($sformatf("%s.pass", tag), int'(pass), 0);
    check($sformatf("%s.fail", tag), int'(fail), 0);
    check($sformatf("%s.fail_code", tag), int'(fail_code), 0);
    check($sformatf("%s.cycle_count", tag), int'(cycle_count), 0);
  endtask

  // One run: start pulse, per-cycle stimulus (RST-phase success is random noise
  // that must be ignored; RUN-phase success goes high at run cycle succ and stays).
  task automatic run_one(input string tag, input int ab_rst, input int ab_run, input int succ,
                         input bit mid_start, input int e_pass, input int e_fail,
                         input int e_code, input int e_count);
    int  trace_n, busy_n, rlow_n, e_busy, k;
    bit  got;
    trace_n = 0; busy_n = 0; rlow_n = 0; got = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check($sformatf("%s.clear", tag), int'({pass, fail, done}), 0);
    check($sformatf("%s.busy_rst", tag), int'(busy), 1);
    for (int c = 0; c < 200; c++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      trace_n += int'(trace_en);
      busy_n  += int'(busy);
      rlow_n  += int'(!dut_reset);
      if (c < RC) begin
        abort       = (c == ab_rst);
        dut_success = 1'($urandom_range(0, 1));
        start       = mid_start && (c == 0);
      end else begin
        k           = c - RC;
        abort       = (k == ab_run);
        dut_success = (succ >= 0) && (k >= succ);
        start       = 1'b0;
      end
      @(negedge clock);
    end
    abort = 1'b0; dut_success = 1'b0; start = 1'b0;
    e_busy = (e_code == 2 && e_count == 0) ? ab_rst + 1 : RC + e_count;
    check($sformatf("%s.verdict_seen", tag), int'(got), 1);
    check($sformatf("%s.pass", tag), int'(pass), e_pass);
    check($sformatf("%s.fail", tag), int'(fail), e_fail);
    check($sformatf("%s.fail_code", tag), int'(fail_code), e_code);
    check($sformatf("%s.cycle_count", tag), int'(cycle_count), e_count);
    check($sformatf("%s.trace_cycles", tag), trace_n, e_count);
    check($sformatf("%s.release_cycles", tag), rlow_n, e_count);
    check($sformatf("%s.busy_cycles", tag), busy_n, e_busy);
    check($sformatf("%s.post_state", tag), int'({dut_reset, trace_en, busy}), 3'b100);
    $display("run %s: abort_rst=%0d abort_run=%0d succ=%0d -> pass=%0d fail=%0d code=%0d count=%0d",
             tag, ab_rst, ab_run, succ, pass, fail, fail_code, cycle_count);
    if (mid_start) begin
      repeat (4) @(negedge clock);
      check($sformatf("%s.no_second_run", tag), int'({busy, done, pass}), {1'b0, 1'b1, 1'(e_pass)});
    end
  endtask

  typedef struct {
    int ab_rst;
    int ab_run;
    int succ;
    int e_pass;
    int e_fail;
    int e_code;
    int e_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int mp, mf, mc, mn, ar, au, sc, gap;

    vecs[0] = '{-1, -1,  4, 1, 0, 0,  5};
    vecs[1] = '{-1, -1, -1, 0, 1, 1, 21};
    vecs[2] = '{-1, -1, 20, 1, 0, 0, 21};
    vecs[3] = '{-1, -1, 21, 0, 1, 1, 21};
    vecs[4] = '{ 0, -1, -1, 0, 1, 2,  0};
    vecs[5] = '{ 1, -1,  0, 0, 1, 2,  0};
    vecs[6] = '{-1,  3,  3, 0, 1, 2,  4};
    vecs[7] = '{-1, -1,  0, 1, 0, 0,  1};
    vecs[8] = '{-1,  0, -1, 0, 1, 2,  1};
    vecs[9] = '{-1,  5,  2, 1, 0, 0,  3};

    reset = 1'b1; start = 1'b0; abort = 1'b0; dut_success = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    abort = 1'b1; dut_success = 1'b1;
    @(negedge clock);
    abort = 1'b0; dut_success = 1'b0;
    check("idle_abort_ignored", int'({busy, done, fail}), 0);

    for (int i = 0; i < 10; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].ab_rst, vecs[i].ab_run, vecs[i].succ, 1'b0,
              vecs[i].e_pass, vecs[i].e_fail, vecs[i].e_code, vecs[i].e_count);
    end

    // Reset mid-run at RUN cycle 7, then a clean run must follow.
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (RC + 7) @(negedge clock);
    check("midrun.in_run", int'({trace_en, busy, dut_reset}), 3'b110);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_values("midrun_reset");
    $display("run midrun_reset: outputs back to reset values");
    run_one("after_reset", -1, -1, 4, 1'b0, 1, 0, 0, 5);

    // Back-to-back rerun after PASS with a second start pulse inside RST.
    run_one("rerun_midstart", -1, -1, 2, 1'b1, 1, 0, 0, 3);

    for (int r = 0; r < 40; r++) begin
      ar = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, RC - 1)) : -1;
      au = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
      sc = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 25)) : -1;
      model(ar, au, sc, mp, mf, mc, mn);
      run_one($sformatf("rnd%0d", r), ar, au, sc, 1'b0, mp, mf, mc, mn);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        abort       = 1'($urandom_range(0, 1));
        dut_success = 1'($urandom_range(0, 1));
        @(negedge clock);
      end
      abort = 1'b0; dut_success = 1'b0;
      check($sformatf("rnd%0d.held", r), int'({done, pass, fail}), {1'b1, 1'(mp), 1'(mf)});
      check($sformatf("rnd%0d.held_count", r), int'(cycle_count), mn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sim_run_controller.md
# sim_run_controller

Sequencer that runs one pass/fail experiment on a DUT with a `clock`/`reset`/`success` port contract. It holds the DUT in reset for a programmable number of cycles, releases it, and watches `success` against a cycle budget. It also gates waveform tracing to the run window and reports a sticky verdict with the elapsed cycle count. It sits between the DPI-driven simulation body and the DUT: the host pulses `start` and polls `done`/`pass`/`fail`.

## Interface
- `RESET_CYCLES`, default 2 — cycles the DUT reset is held after `start`; legal range ≥1.
- `TIMEOUT_CYCLES`, default 21 — run-cycle budget; `success` must be seen within this many RUN cycles; legal range ≥1.
- `CNT_W`, default 16 — width of the cycle counters; requires `TIMEOUT_CYCLES < 2**CNT_W` and `RESET_CYCLES < 2**CNT_W`.

Ports:
- `clock`  in  1  — sole clock; everything is rising-edge.
- `reset`  in  1  — synchronous, active-high. One clock; reset is synchronous and active-high.
- `start`  in  1  — single-cycle request to begin a run; ignored while `busy`.
- `abort`  in  1  — terminate the current run as failed; ignored when not `busy`.
- `dut_success`  in  1  — DUT `success` output.
- `dut_reset`  out  1  — drives the DUT `reset` input.
- `trace_en`  out  1  — high only during RUN; drives trace on/off.
- `busy`  out  1  — high in RESET and RUN.
- `done`  out  1  — sticky verdict valid; high in PASS and FAIL.
- `pass`  out  1  — sticky; the run saw `dut_success` in time.
- `fail`  out  1  — sticky; the run timed out or was aborted.
- `fail_code`  out  2  — 00 none, 01 timeout, 10 abort.
- `cycle_count`  out  CNT_W  — number of RUN cycles elapsed; frozen at the verdict.

## Operation
- States: IDLE, RST, RUN, PASS, FAIL. All outputs are registered, or are pure decodes of state registers.
- Reset values:
  - State is IDLE.
  - `dut_reset`=1, all other outputs 0.
  - Internal `rst_cnt`=0.
- IDLE:
  - `dut_reset`=1, so the DUT is held.
  - `start` → RST. Clears `rst_cnt`, `cycle_count`, `pass`, `fail`, `fail_code`.
- RST:
  - `dut_reset`=1, `busy`=1. `rst_cnt` increments each cycle.
  - In the cycle where `rst_cnt == RESET_CYCLES-1` → RUN.
  - `abort` → FAIL with code 10. Abort has priority over the RST→RUN transition.
- RUN:
  - `dut_reset`=0, `trace_en`=1, `busy`=1.
  - Let k = `cycle_count` in the current cycle; the first RUN cycle has k=0. Priority per cycle:
    1. `abort` → FAIL, code 10, `cycle_count` ← k+1.
    2. `dut_success` → PASS, `cycle_count` ← k+1.
    3. k+1 == `TIMEOUT_CYCLES` → FAIL, code 01, `cycle_count` ← k+1.
    4. Otherwise `cycle_count` ← k+1 and remain in RUN.
  - `dut_success` is sampled only in RUN. Any value during RST or IDLE is ignored.
- PASS / FAIL:
  - `done`=1, `busy`=0, `dut_reset`=1 (DUT re-held), `trace_en`=0.
  - Verdict outputs and `cycle_count` hold until the next `start`.
  - `start` → RST with the same clearing as from IDLE. This is a back-to-back rerun; returning to IDLE is not required.
- `start` while `busy` has no effect. `abort` outside RST/RUN has no effect.
- Counter arithmetic is unsigned CNT_W and never wraps under the legal parameter ranges.
- Asserting `reset` at any point, including mid-run, returns to IDLE with reset values on the next edge. No partial verdict is kept.

## Timing
- `start` sampled at edge t:
  - Cycles t+1 … t+RESET_CYCLES are RST.
  - RUN begins at t+RESET_CYCLES+1.
  - `dut_reset` falls at the edge beginning RUN.
- Verdict latency: the decision is made in RUN cycle k. At the next edge, `done` and `pass`/`fail` rise and `dut_reset` rises.
- `dut_success` high in the first RUN cycle gives `pass`, `cycle_count`=1. This is the minimum run.
- `dut_success` first high in RUN cycle k=TIMEOUT_CYCLES-1 gives PASS, because success outranks timeout. Any later success is too late, since FAIL has already been taken.
- `trace_en` is high for exactly `cycle_count` cycles per run.

## Test plan
- Defaults (2, 21). `start` at cycle 0; `dut_success` rises in RUN cycle 4 → `dut_reset` high for cycles 1–2 and low from 3; `pass`=1 and `done`=1 at cycle 8; `cycle_count`=5; `fail_code`=00.
- Defaults; `dut_success` held 0 → FAIL after 21 RUN cycles; `cycle_count`=21; `fail_code`=01; `trace_en` high for 21 cycles.
- Defaults; `dut_success` first high in RUN cycle 20 → PASS with `cycle_count`=21. Same test with the high in RUN cycle 21 → FAIL/01.
- `abort` in RST, and separately in RUN cycle 3 together with `dut_success`=1 → FAIL, code 10; in the RUN case `cycle_count`=4.
- `reset` pulsed in RUN cycle 7 → next cycle all outputs are at reset values and state is IDLE. A following `start` gives a clean run.
- After PASS, `start` again with a second `start` pulse mid-RST → exactly one new run; the mid-RST pulse is ignored; `pass` clears at the first RST cycle.
